fsm_event_monitor: RTL and testbench

- Downstream consumer of the 1-bit Moore detector output.
- Counts rising edges of that output over fixed windows of WINDOW clock cycles and tracks the longest high run in each window.
- At each window end, publishes count, longest run and overflow with a one-cycle valid strobe.
- Raises a sticky alarm when a window's count reaches a programmable threshold.

---
 rtl/fsm_event_monitor.sv | 96 +++++++++
 tb/tb_fsm_event_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_event_monitor.sv
// fsm_event_monitor: windowed rising-edge counter and longest-run tracker with a sticky threshold alarm
// Ports: clock, reset (async, active-high); event_in (detector output), enable (run windows back-to-back),
//   clear (sync clear of all state), threshold (alarm level, 0 disables); busy (COUNT or REPORT),
//   count_out / run_max / count_ovf (results of the last completed window), count_valid (1-cycle strobe),
//   alarm (sticky).
module fsm_event_monitor #(
  parameter int WINDOW = 16,
  parameter int CNT_W = 8,
  parameter int RUN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             event_in,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] threshold,
  output logic             busy,
  output logic [CNT_W-1:0] count_out,
  output logic [RUN_W-1:0] run_max,
  output logic             count_ovf,
  output logic             count_valid,
  output logic             alarm
);
  localparam int WW = $clog2(WINDOW);
  typedef enum logic [1:0] {IDLE, COUNT, REPORT} state_t;
  state_t state, state_next;
  logic event_d, rise, load, terminal, ovf, ovf_n;
  logic [WW-1:0] win_cnt;
  logic [CNT_W-1:0] acc, acc_n;
  logic [RUN_W-1:0] run_cur, run_best, run_n, best_n;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_comb
    state_next = clear ? IDLE :
                 state == COUNT ? (!enable ? IDLE : win_cnt == '0 ? REPORT : COUNT) :
                 enable ? COUNT : IDLE;
  always_comb begin
    busy = state != IDLE;
    count_valid = state == REPORT;
  end
  // Next-cycle accumulator values; the terminal cycle latches these so its own rise/run is included.
  always_comb begin
    rise = event_in & ~event_d;
    acc_n = acc + CNT_W'(rise & !(&acc));
    ovf_n = ovf | (rise & (&acc));
    run_n = event_in ? run_cur + RUN_W'(!(&run_cur)) : '0;
    best_n = run_n > run_best ? run_n : run_best;
    load = state != COUNT && enable;
    terminal = state == COUNT && enable && win_cnt == '0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      event_d <= 1'b0;
      win_cnt <= '0;
      acc <= '0;
      ovf <= 1'b0;
      run_cur <= '0;
      run_best <= '0;
      count_out <= '0;
      run_max <= '0;
      count_ovf <= 1'b0;
      alarm <= 1'b0;
    end else begin
      event_d <= event_in;
      if (clear) begin
        win_cnt <= '0;
        acc <= '0;
        ovf <= 1'b0;
        run_cur <= '0;
        run_best <= '0;
        count_out <= '0;
        run_max <= '0;
        count_ovf <= 1'b0;
        alarm <= 1'b0;
      end else if (load) begin
        win_cnt <= WW'(WINDOW - 1);
        acc <= '0;
        ovf <= 1'b0;
        run_cur <= '0;
        run_best <= '0;
      end else if (state == COUNT) begin
        win_cnt <= win_cnt - WW'(1);
        acc <= acc_n;
        ovf <= ovf_n;
        run_cur <= run_n;
        run_best <= best_n;
        if (terminal) begin
          count_out <= acc_n;
          run_max <= best_n;
          count_ovf <= ovf_n;
          alarm <= alarm | (threshold != '0 && acc_n >= threshold);
        end
      end
    end
endmodule

// File: tb/tb_fsm_event_monitor.sv
// tb_fsm_event_monitor: scoreboard bench for fsm_event_monitor against a window-history reference model
module tb_fsm_event_monitor;
  localparam int WINDOW = 16;
  localparam int CNT_W = 3;
  localparam int RUN_W = 3;
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam int RMAX = (1 << RUN_W) - 1;
  typedef struct {
    int cyc;
    bit busy;
    bit valid;
    int cnt;
    int run;
    bit ovf;
    bit alarm;
  } exp_t;
  logic clock, reset, event_in, enable, clear;
  logic [CNT_W-1:0] threshold;
  logic busy, count_ovf, count_valid, alarm;
  logic [CNT_W-1:0] count_out;
  logic [RUN_W-1:0] run_max;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t exp_q[$];
  int m_ph = 0;
  bit start_lvl = 0;
  bit win_q[$];
  int o_cnt = 0;
  int o_run = 0;
  bit o_ovf = 0;
  bit o_alarm = 0;
  bit o_valid = 0;
  fsm_event_monitor #(.WINDOW(WINDOW), .CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
    .clock(clock),
    .reset(reset),
    .event_in(event_in),
    .enable(enable),
    .clear(clear),
    .threshold(threshold),
    .busy(busy),
    .count_out(count_out),
    .run_max(run_max),
    .count_ovf(count_ovf),
    .count_valid(count_valid),
    .alarm(alarm)
  );
  initial clock = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Scores a finished window from its recorded samples: rises, longest run, saturation, alarm.
  task automatic summarise();
    int n = 0;
    int cur = 0;
    int best = 0;
    bit prev = start_lvl;
    foreach (win_q[i]) begin
      if (win_q[i] && !prev) n++;
      cur = win_q[i] ? cur + 1 : 0;
      if (cur > best) best = cur;
      prev = win_q[i];
    end
    o_cnt = n > CMAX ? CMAX : n;
    o_ovf = n > CMAX;
    o_run = best > RMAX ? RMAX : best;
    if (threshold != 0 && o_cnt >= int'(threshold)) o_alarm = 1;
  endtask
  task automatic model_step(input bit ev, input bit en, input bit cl, input bit rs);
    o_valid = 0;
    if (rs || cl) begin
      m_ph = 0;
      o_cnt = 0;
      o_run = 0;
      o_ovf = 0;
      o_alarm = 0;
      win_q.delete();
    end else if (m_ph == 1) begin
      if (!en) m_ph = 0;
      else begin
        win_q.push_back(ev);
        if (win_q.size() == WINDOW) begin
          summarise();
          o_valid = 1;
          m_ph = 2;
        end
      end
    end else if (en) begin
      m_ph = 1;
      win_q.delete();
      start_lvl = ev;
    end else m_ph = 0;
  endtask
  task automatic cycle(input bit ev, input bit en, input bit cl = 0, input bit rs = 0);
    exp_t e;
    event_in = ev;
    enable = en;
    clear = cl;
    reset = rs;
    if (rs) exp_q.delete();
    model_step(ev, en, cl, rs);
    e.cyc = cyc + 1;
    e.busy = m_ph != 0;
    e.valid = o_valid;
    e.cnt = o_cnt;
    e.run = o_run;
    e.ovf = o_ovf;
    e.alarm = o_alarm;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask
  task automatic body(input logic [WINDOW:1] p);
    for (int k = 1; k <= WINDOW; k++) cycle(p[k], 1);
  endtask
  task automatic expect_out(input string tag, input int c, input int r, input bit o, input bit a);
    chk({tag, " count_out"}, count_out, c);
    chk({tag, " run_max"}, run_max, r);
    chk({tag, " count_ovf"}, count_ovf, o);
    chk({tag, " alarm"}, alarm, a);
  endtask
  always @(negedge clock) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("stale expectation", e.cyc, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("busy", busy, e.busy);
      chk("count_valid", count_valid, e.valid);
      chk("count_out", count_out, e.cnt);
      chk("run_max", run_max, e.run);
      chk("count_ovf", count_ovf, e.ovf);
      chk("alarm", alarm, e.alarm);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int pct;
    threshold = 0;
    repeat (3) cycle(0, 0, 0, 1);
    repeat (2) cycle(0, 0);
    expect_out("reset", 0, 0, 0, 0);
    chk("reset busy", busy, 0);
    cycle(0, 1);
    body(16'h0222);
    expect_out("basic", 3, 1, 0, 0);
    cycle(0, 0);
    repeat (2) cycle(1, 0);
    cycle(1, 1);
    body(16'h0F1F);
    expect_out("level", 1, 5, 0, 0);
    cycle(0, 0);
    cycle(0, 0);
    cycle(0, 1);
    body(16'hAAAA);
    expect_out("sat", 7, 1, 1, 0);
    cycle(0, 1);
    body(16'h0044);
    expect_out("post-sat", 2, 1, 0, 0);
    cycle(0, 0);
    threshold = 3;
    cycle(0, 1);
    body(16'h0044);
    expect_out("alarm count2", 2, 1, 0, 0);
    cycle(0, 1);
    body(16'h0222);
    expect_out("alarm count3", 3, 1, 0, 1);
    cycle(0, 1);
    body(16'h0000);
    expect_out("alarm sticky", 0, 0, 0, 1);
    cycle(0, 0);
    cycle(0, 0, 1);
    expect_out("clear", 0, 0, 0, 0);
    threshold = 0;
    cycle(0, 1);
    body(16'h02AA);
    expect_out("thr0", 5, 1, 0, 0);
    cycle(0, 0);
    cycle(0, 1);
    for (int k = 1; k <= 7; k++) cycle(k == 3, 1);
    cycle(0, 0);
    expect_out("abort", 5, 1, 0, 0);
    chk("abort busy", busy, 0);
    cycle(0, 0);
    cycle(0, 1);
    body(16'h8000);
    expect_out("terminal rise", 1, 1, 0, 0);
    cycle(0, 1);
    body(16'h0000);
    expect_out("quiet", 0, 0, 0, 0);
    cycle(1, 1);
    body(16'h0001);
    expect_out("report rise", 0, 1, 0, 0);
    cycle(0, 0);
    threshold = 1;
    cycle(0, 1);
    body(16'h0222);
    expect_out("pre-reset", 3, 1, 0, 1);
    cycle(0, 1);
    cycle(1, 1);
    cycle(0, 1);
    cycle(1, 1, 0, 1);
    expect_out("mid reset", 0, 0, 0, 0);
    chk("mid reset busy", busy, 0);
    cycle(0, 0, 0, 1);
    threshold = 0;
    for (int k = 0; k < 40; k++) cycle(k[0], 0);
    pct = 50;
    for (int k = 0; k < 1500; k++) begin
      if (k % 100 == 0) pct = $urandom_range(0, 2) * 40 + 10;
      if ($urandom_range(0, 49) == 0) threshold = CNT_W'($urandom_range(0, CMAX));
      cycle($urandom_range(0, 99) < pct, $urandom_range(0, 39) != 0,
            $urandom_range(0, 199) == 0, $urandom_range(0, 499) == 0);
    end
    @(negedge clock);
    #1;
    chk("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
